// File: rtl/bram_arb_pkg.sv
// Shared types and helpers for the two-requester BRAM port arbiter.
package bram_arb_pkg;

  // Requester index width: two requesters, so one bit.
  localparam int ID_W = 1;

  typedef logic [ID_W-1:0] req_id_t;

  // One stage of the read-tag pipeline that follows a read through the BRAM.
  typedef struct packed {
    logic    valid;
    req_id_t id;
  } tag_t;

  // BRAM read latency: the output register adds one cycle.
  function automatic int read_latency(input bit pipelined);
    return pipelined ? 2 : 1;
  endfunction

  // Credit counters must hold the value RESP_DEPTH itself.
  function automatic int credit_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/bram_arb_rsp_fifo.sv
// Per-requester response FIFO. Pushes come from the tag pipeline, pops
// from the response consumer; a pop while empty is ignored.
module bram_arb_rsp_fifo
  import bram_arb_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int RESP_DEPTH = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 push_i,
  input  logic [DATA_WIDTH-1:0]                push_data_i,
  input  logic                                 pop_i,
  output logic [DATA_WIDTH-1:0]                data_o,
  output logic                                 valid_o,
  output logic [credit_width(RESP_DEPTH)-1:0]  count_o
);

  localparam int PW = $clog2(RESP_DEPTH);
  localparam int CW = credit_width(RESP_DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [RESP_DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  do_pop;

  assign do_pop = pop_i & (count_q != '0);

  // Next-state pointers and occupancy.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_i) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop) rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push_i, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: ;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage.
  // NOTE: the storage array is not reset; occupancy qualifies every read, and no reset keeps it RAM-mappable.
  always_ff @(posedge clk) begin
    if (push_i) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign data_o  = mem_q[rd_ptr_q];
  assign valid_o = (count_q != '0);
  assign count_o = count_q;

  // Credit accounting guarantees room for every push; a full push would lose read data.
  a_no_full_push: assert property (@(posedge clk) disable iff (rst)
    !(push_i && (count_q == CW'(RESP_DEPTH))));

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one BRAM port between two requesters. Reads
// are tagged through a latency-matched pipeline and steered into a
// per-requester response FIFO; credits stop reads that could overflow it.
module bram_port_arbiter
  import bram_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int PIPELINED  = 1,
  parameter int RESP_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ0_VALID,
  output logic                  REQ0_READY,
  input  logic                  REQ0_WRITE,
  input  logic [ADDR_WIDTH-1:0] REQ0_ADDR,
  input  logic [DATA_WIDTH-1:0] REQ0_WDATA,
  input  logic                  REQ1_VALID,
  output logic                  REQ1_READY,
  input  logic                  REQ1_WRITE,
  input  logic [ADDR_WIDTH-1:0] REQ1_ADDR,
  input  logic [DATA_WIDTH-1:0] REQ1_WDATA,
  output logic                  RSP0_VALID,
  input  logic                  RSP0_READY,
  output logic [DATA_WIDTH-1:0] RSP0_DATA,
  output logic                  RSP1_VALID,
  input  logic                  RSP1_READY,
  output logic [DATA_WIDTH-1:0] RSP1_DATA,
  output logic                  BRAM_EN,
  output logic                  BRAM_WE,
  output logic [ADDR_WIDTH-1:0] BRAM_RADDR,
  output logic [ADDR_WIDTH-1:0] BRAM_WADDR,
  output logic [DATA_WIDTH-1:0] BRAM_DI,
  input  logic [DATA_WIDTH-1:0] BRAM_DO
);

  localparam int            LAT     = read_latency(PIPELINED != 0);
  localparam int            CW      = credit_width(RESP_DEPTH);
  localparam logic [CW-1:0] DEPTH_C = CW'(RESP_DEPTH);

  logic [1:0]            req_valid, req_write, eligible, grant;
  logic [1:0]            rsp_push, rsp_pop, rsp_valid, rsp_ready;
  logic [ADDR_WIDTH-1:0] req_addr  [2];
  logic [DATA_WIDTH-1:0] req_wdata [2];
  logic [DATA_WIDTH-1:0] rsp_data  [2];
  logic [CW-1:0]         credit_q  [2];
  logic [CW-1:0]         credit_d  [2];
  logic [CW-1:0]         fifo_count [2];
  req_id_t               last_grant_q, last_grant_d, grant_id;
  logic                  grant_any, grant_read;
  tag_t                  tag_q [LAT];

  assign req_valid    = {REQ1_VALID, REQ0_VALID};
  assign req_write    = {REQ1_WRITE, REQ0_WRITE};
  assign req_addr[0]  = REQ0_ADDR;
  assign req_addr[1]  = REQ1_ADDR;
  assign req_wdata[0] = REQ0_WDATA;
  assign req_wdata[1] = REQ1_WDATA;
  assign rsp_ready    = {RSP1_READY, RSP0_READY};

  // Eligibility and round-robin grant; nothing is granted during reset.
  always_comb begin
    eligible = '0;
    for (int n = 0; n < 2; n++)
      eligible[n] = req_valid[n] & (req_write[n] | (credit_q[n] < DEPTH_C));
    grant = '0;
    if (!RST) begin
      if (&eligible) grant = (last_grant_q == 1'b1) ? 2'b01 : 2'b10;
      else           grant = eligible;
    end
  end

  assign grant_any    = |grant;
  assign grant_id     = req_id_t'(grant[1]);
  assign grant_read   = grant_any & ~req_write[grant_id];
  assign last_grant_d = grant_any ? grant_id : last_grant_q;
  assign REQ0_READY   = grant[0];
  assign REQ1_READY   = grant[1];

  // Drive the BRAM port from the granted request; idle port drives zeros.
  always_comb begin
    BRAM_EN    = 1'b0;
    BRAM_WE    = 1'b0;
    BRAM_RADDR = '0;
    BRAM_WADDR = '0;
    BRAM_DI    = '0;
    if (grant_any) begin
      BRAM_EN = 1'b1;
      BRAM_WE = req_write[grant_id];
      if (req_write[grant_id]) begin
        BRAM_WADDR = req_addr[grant_id];
        BRAM_DI    = req_wdata[grant_id];
      end else begin
        BRAM_RADDR = req_addr[grant_id];
      end
    end
  end

  // Credit next-state: +1 on a read grant, -1 on a response pop.
  always_comb begin
    for (int n = 0; n < 2; n++) begin
      credit_d[n] = credit_q[n];
      case ({grant[n] & ~req_write[n], rsp_pop[n]})
        2'b10:   credit_d[n] = credit_q[n] + CW'(1);
        2'b01:   credit_d[n] = credit_q[n] - CW'(1);
        default: ;
      endcase
    end
  end

  // Round-robin pointer and credit registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_grant_q <= 1'b1;
      credit_q[0] <= '0;
      credit_q[1] <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      credit_q[0] <= credit_d[0];
      credit_q[1] <= credit_d[1];
    end
  end

  // Tag pipeline matching the BRAM read latency; reset drops in-flight reads.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
    end else begin
      tag_q[0] <= '{valid: grant_read, id: grant_id};
      for (int i = 1; i < LAT; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  for (genvar n = 0; n < 2; n++) begin : g_rsp
    assign rsp_push[n] = tag_q[LAT-1].valid & (tag_q[LAT-1].id == req_id_t'(n));
    assign rsp_pop[n]  = rsp_valid[n] & rsp_ready[n];

    bram_arb_rsp_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .RESP_DEPTH (RESP_DEPTH)
    ) u_fifo (
      .clk         (CLK),
      .rst         (RST),
      .push_i      (rsp_push[n]),
      .push_data_i (BRAM_DO),
      .pop_i       (rsp_pop[n]),
      .data_o      (rsp_data[n]),
      .valid_o     (rsp_valid[n]),
      .count_o     (fifo_count[n])
    );

    // Credit covers the FIFO plus reads in flight and never exceeds the depth.
    a_credit_bound: assert property (@(posedge CLK) disable iff (RST)
      (credit_q[n] <= DEPTH_C) && (credit_q[n] >= fifo_count[n]));
  end

  assign RSP0_VALID = rsp_valid[0];
  assign RSP1_VALID = rsp_valid[1];
  assign RSP0_DATA  = rsp_data[0];
  assign RSP1_DATA  = rsp_data[1];

endmodule
